// File: rtl/pilot_insert_pkg.sv
// Shared definitions for the OFDM pilot/null inserter: subcarrier map,
// pilot base signs, polarity scrambler taps and the inserter FSM encoding.
// Pure definitions; no logic, no latency, no flow control.
package pilot_insert_pkg;

    localparam int NFFT   = 64;  // subcarriers per OFDM symbol
    localparam int N_DATA = 48;  // data subcarriers per symbol

    // Polarity scrambler x^7 + x^4 + 1: feedback is s[6] ^ s[3]
    localparam int POL_TAP_HI = 6;
    localparam int POL_TAP_LO = 3;

    typedef enum logic [1:0] {
        SC_NULL,
        SC_DATA,
        SC_PILOT
    } sc_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NULL,
        ST_DATA,
        ST_PILOT
    } fsm_state_t;

    // Subcarrier class in IFFT natural order: DC and guard band are null
    function automatic sc_class_t sc_class(input logic [5:0] idx);
        sc_class_t c;
        if (idx == 6'd0 || (idx >= 6'd27 && idx <= 6'd37)) begin
            c = SC_NULL;
        end else if (idx == 6'd7 || idx == 6'd21 || idx == 6'd43 || idx == 6'd57) begin
            c = SC_PILOT;
        end else begin
            c = SC_DATA;
        end
        return c;
    endfunction

    // Pilot at subcarrier 21 carries a negative base value; the others positive
    function automatic logic pilot_base_neg(input logic [5:0] idx);
        return (idx == 6'd21);
    endfunction

    // FSM state that serves a given (non-zero) subcarrier index
    function automatic fsm_state_t class_state(input logic [5:0] idx);
        fsm_state_t s;
        case (sc_class(idx))
            SC_NULL:  s = ST_NULL;
            SC_PILOT: s = ST_PILOT;
            default:  s = ST_DATA;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered-ready output stage carrying a W-bit payload.
// Latency: 1 cycle from i_in_vld & o_in_rdy to o_out_vld when empty.
// Backpressure: o_in_rdy is a flop output (no path from i_out_rdy); o_out_dat holds while stalled.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_in_vld / o_in_rdy   write side handshake, i_in_dat payload
//   o_out_vld / i_out_rdy read side handshake, o_out_dat payload
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_vld,
    output logic         o_in_rdy,
    input  logic [W-1:0] i_in_dat,
    output logic         o_out_vld,
    input  logic         i_out_rdy,
    output logic [W-1:0] o_out_dat
);

    logic         r_main_vld;
    logic [W-1:0] r_main_dat;
    logic         r_skid_vld;
    logic [W-1:0] r_skid_dat;

    logic w_main_free;
    logic w_in_fire;

    // The main register can take a new word if it is empty or being drained now
    assign w_main_free = !r_main_vld || i_out_rdy;
    assign w_in_fire   = i_in_vld && !r_skid_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (w_main_free) begin
            if (r_skid_vld) begin
                // Input is blocked while the skid is full, so only the skid moves
                r_main_vld <= 1'b1;
                r_main_dat <= r_skid_dat;
                r_skid_vld <= 1'b0;
            end else begin
                r_main_vld <= w_in_fire;
                if (w_in_fire) begin
                    r_main_dat <= i_in_dat;
                end
            end
        end else if (w_in_fire) begin
            // Main is stalled: park the word accepted on the registered ready
            r_skid_vld <= 1'b1;
            r_skid_dat <= i_in_dat;
        end
    end

    assign o_in_rdy  = !r_skid_vld;
    assign o_out_vld = r_main_vld;
    assign o_out_dat = r_main_dat;

endmodule

// File: rtl/pilot_insert_axis_param.sv
// OFDM pilot/null inserter: 48 data samples in, 64 subcarriers out per symbol.
// Latency: 1 cycle from input handshake (or generated null/pilot) to m_axis_tvalid.
// Backpressure: registered-ready skid stage; s_axis_tready only in DATA with stage ready.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_t{valid,ready,data}     {Q,I} data samples from the mapper
//   s_axis_tlast                   last data sample of symbol (checked only)
//   s_axis_tuser                   first sample of frame, restarts pilot polarity
//   m_axis_t{valid,ready,data}     {Q,I} subcarriers in IFFT natural order
//   m_axis_tlast                   subcarrier 63
//   err_len                        one-cycle pulse on input tlast/count mismatch
module pilot_insert_axis_param
    import pilot_insert_pkg::*;
#(
    parameter int         DW        = 16,
    parameter int         PILOT_AMP = 2 ** (DW - 1) - 1,
    parameter bit         POL_EN    = 1'b1,
    parameter logic [6:0] POL_SEED  = 7'h7F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [2*DW-1:0] s_axis_tdata,
    input  logic          s_axis_tlast,
    input  logic          s_axis_tuser,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [2*DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    output logic          err_len
);

    localparam logic [DW-1:0] AMP_POS = DW'(PILOT_AMP);
    localparam logic [DW-1:0] AMP_NEG = DW'(-PILOT_AMP);

    fsm_state_t r_state;
    fsm_state_t w_state_nxt;

    logic [5:0] r_sc_idx;
    logic [5:0] r_dat_cnt;
    logic [6:0] r_lfsr;
    logic       r_pol_neg;
    logic       r_err_len;

    logic            w_stage_rdy;
    logic            w_wr;
    logic            w_sym_start;
    logic            w_dat_acc;
    logic            w_s_tready;
    logic [5:0]      w_sc_nxt;
    logic [2*DW-1:0] w_wr_dat;
    logic            w_last;
    logic [DW-1:0]   w_pilot_i;
    logic [6:0]      w_lfsr_cur;
    logic            w_pol_bit;
    logic [2*DW:0]   w_out_dat;

    // Frame start restarts the scrambler from the seed before this symbol's pilots.
    // r_lfsr always holds the state whose output applies to the next symbol, so
    // the first symbol after reset uses the seed without a preceding step.
    assign w_lfsr_cur = s_axis_tuser ? POL_SEED : r_lfsr;
    assign w_pol_bit  = w_lfsr_cur[POL_TAP_HI] ^ w_lfsr_cur[POL_TAP_LO];

    assign w_pilot_i = (pilot_base_neg(r_sc_idx) ^ (POL_EN & r_pol_neg)) ? AMP_NEG : AMP_POS;
    assign w_last    = (r_sc_idx == 6'(NFFT - 1));

    always_comb begin
        w_wr        = 1'b0;
        w_sym_start = 1'b0;
        w_dat_acc   = 1'b0;
        w_s_tready  = 1'b0;
        w_wr_dat    = '0;
        w_sc_nxt    = r_sc_idx + 6'd1;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // Peek only: the sample itself is taken later in ST_DATA
                if (s_axis_tvalid && w_stage_rdy) begin
                    w_wr        = 1'b1;
                    w_sym_start = 1'b1;
                end
            end
            ST_NULL: begin
                w_wr = w_stage_rdy;
            end
            ST_PILOT: begin
                w_wr     = w_stage_rdy;
                w_wr_dat = {{DW{1'b0}}, w_pilot_i};
            end
            ST_DATA: begin
                w_s_tready = w_stage_rdy;
                if (s_axis_tvalid && w_stage_rdy) begin
                    w_wr      = 1'b1;
                    w_dat_acc = 1'b1;
                    w_wr_dat  = s_axis_tdata;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_wr) begin
            w_state_nxt = (w_sc_nxt == 6'd0) ? ST_IDLE : class_state(w_sc_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc_idx  <= '0;
            r_dat_cnt <= '0;
            r_lfsr    <= POL_SEED;
            r_pol_neg <= 1'b0;
            r_err_len <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            if (w_wr) begin
                r_sc_idx <= w_sc_nxt;
            end
            if (w_sym_start) begin
                r_lfsr    <= {w_lfsr_cur[5:0], w_pol_bit};
                r_pol_neg <= w_pol_bit;
                r_dat_cnt <= '0;
            end
            if (w_dat_acc) begin
                // Counting stays authoritative; a tlast mismatch is only flagged
                r_dat_cnt <= r_dat_cnt + 6'd1;
                r_err_len <= s_axis_tlast != (r_dat_cnt == 6'(N_DATA - 1));
            end
        end
    end

    axis_skid_buf #(
        .W(2 * DW + 1)
    ) u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .i_in_vld (w_wr),
        .o_in_rdy (w_stage_rdy),
        .i_in_dat ({w_last, w_wr_dat}),
        .o_out_vld(m_axis_tvalid),
        .i_out_rdy(m_axis_tready),
        .o_out_dat(w_out_dat)
    );

    assign m_axis_tlast  = w_out_dat[2*DW];
    assign m_axis_tdata  = w_out_dat[2*DW-1:0];
    assign s_axis_tready = w_s_tready;
    assign err_len       = r_err_len;

endmodule

// File: tb/tb_pilot_insert_axis_param.sv
// Bench for the pilot inserter: random data against a subcarrier-map model,
// explicit constants for the first symbol, polarity sign sequence checks,
// backpressure stability, length errors, mid-symbol reset and a DW=12 / POL_EN=0 instance.
module tb_pilot_insert_axis_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast, err_len;
    logic [31:0] m_tdata;

    logic        s2_tvalid, s2_tready, s2_tlast, s2_tuser;
    logic [23:0] s2_tdata;
    logic        m2_tvalid, m2_tready, m2_tlast, err2;
    logic [23:0] m2_tdata;

    pilot_insert_axis_param dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .err_len(err_len)
    );

    pilot_insert_axis_param #(.DW(12), .POL_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready), .s_axis_tdata(s2_tdata),
        .s_axis_tlast(s2_tlast), .s_axis_tuser(s2_tuser),
        .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready), .m_axis_tdata(m2_tdata),
        .m_axis_tlast(m2_tlast), .err_len(err2)
    );

    int          tests = 0;
    int          fails = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    int          beat_cyc[$];
    int          cyc = 0;
    int          err_cnt = 0;
    int          stab_err = 0;
    bit          rnd_ready = 1'b0;
    logic        hold_v = 1'b0;
    logic [32:0] hold_d = '0;
    logic [31:0] sym_dat[48];
    bit          pol_tbl[127];
    int          k_model = 0;

    always @(posedge clk) cyc++;

    // Output monitor: inputs change just after posedge, so negedge values are
    // exactly what the next posedge will see.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && (!m_tvalid || {m_tlast, m_tdata} !== hold_d)) stab_err++;
            if (m_tvalid && m_tready) begin
                got_q.push_back({m_tlast, m_tdata});
                beat_cyc.push_back(cyc);
            end
            hold_v = m_tvalid && !m_tready;
            hold_d = {m_tlast, m_tdata};
            if (err_len) err_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference: expected 64 beats of one symbol from the subcarrier map and
    // the polarity sequence index counted since the last frame restart.
    task automatic model_symbol(input bit user);
        bit pn;
        bit neg;
        int d;
        logic [31:0] v;
        d = 0;
        if (user) k_model = 0;
        pn = pol_tbl[k_model % 127];
        k_model++;
        for (int sc = 0; sc < 64; sc++) begin
            if (sc == 0 || (sc >= 27 && sc <= 37)) begin
                v = 32'h0;
            end else if (sc == 7 || sc == 21 || sc == 43 || sc == 57) begin
                neg = (sc == 21) ^ pn;
                v = neg ? 32'h0000_8001 : 32'h0000_7FFF;
            end else begin
                v = sym_dat[d];
                d++;
            end
            exp_q.push_back({1'(sc == 63), v});
        end
    endtask

    task automatic drive_symbol(input bit user, input int bad_at, input bit miss_last, input bit gaps);
        bit acc;
        int n;
        for (int i = 0; i < 48; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_tvalid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = sym_dat[i];
            s_tuser  = (i == 0) ? user : (gaps && $urandom_range(0, 7) == 0);
            s_tlast  = (i == 47 && !miss_last) || (i == bad_at);
            n = 0;
            do begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                n++;
            end while (!acc && n < 3000);
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL input_stall sample=%0d ready=0 required=1", i);
                s_tvalid = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        got_q.delete();
        exp_q.delete();
        beat_cyc.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
        tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got=%b exp=0", m_tlast); end
        tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rst_err_len got=%b exp=0", err_len); end
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL idle_tready got=%b exp=0", s_tready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_one_symbol;
        int e0;
        int nlast;
        int chk_idx[9];
        logic [32:0] chk_val[9];
        rnd_ready = 1'b0;
        clear_q();
        e0 = err_cnt;
        for (int i = 0; i < 48; i++) sym_dat[i] = 32'(i + 1);
        model_symbol(1'b1);
        drive_symbol(1'b1, -1, 1'b0, 1'b0);
        wait_out(500);
        tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL one_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL one_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        chk_idx = '{0, 1, 6, 7, 21, 30, 43, 57, 63};
        chk_val = '{33'h0, 33'h1, 33'h6, 33'h7FFF, 33'h8001, 33'h0, 33'h7FFF, 33'h7FFF, 33'h1_0000_0030};
        if (got_q.size() >= 64) begin
            for (int i = 0; i < 9; i++) begin
                tests++;
                if (got_q[chk_idx[i]] !== chk_val[i]) begin
                    fails++; $display("FAIL one_const_sc%0d got=%h exp=%h", chk_idx[i], got_q[chk_idx[i]], chk_val[i]);
                end
            end
            nlast = 0;
            for (int i = 0; i < 64; i++) if (got_q[i][32]) nlast++;
            tests++; if (nlast !== 1) begin fails++; $display("FAIL one_tlast_count got=%0d exp=1", nlast); end
        end
        tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL one_err_len got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        bit exp_neg[8];
        bit neg;
        for (int pass = 0; pass < 2; pass++) begin
            rnd_ready = 1'b0;
            clear_q();
            if (pass == 0) exp_neg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            else           exp_neg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            for (int s = 0; s < 8; s++) begin
                bit user;
                user = (s == 0) || (pass == 1 && s == 5);
                for (int i = 0; i < 48; i++) sym_dat[i] = $urandom;
                model_symbol(user);
                drive_symbol(user, -1, 1'b0, 1'b0);
            end
            wait_out(2000);
            tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b%0d_count got=%0d exp=%0d", pass, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b%0d_beat%0d got=%h exp=%h", pass, i, got_q[i], exp_q[i]); end
            end
            if (got_q.size() == 512) begin
                for (int s = 0; s < 8; s++) begin
                    neg = (got_q[s * 64 + 7][31:0] == 32'h0000_8001);
                    tests++; if (neg !== exp_neg[s]) begin fails++; $display("FAIL b2b%0d_sc7_sign sym=%0d got_neg=%b exp_neg=%b", pass, s, neg, exp_neg[s]); end
                end
                tests++;
                if (beat_cyc[511] - beat_cyc[0] !== 511) begin
                    fails++; $display("FAIL b2b%0d_rate got_span=%0d exp_span=511", pass, beat_cyc[511] - beat_cyc[0]);
                end
            end
        end
    endtask

    task automatic test_random_backpressure;
        int s0;
        clear_q();
        rnd_ready = 1'b1;
        s0 = stab_err;
        for (int s = 0; s < 6; s++) begin
            bit user;
            user = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 48; i++) sym_dat[i] = $urandom;
            model_symbol(user);
            drive_symbol(user, -1, 1'b0, 1'b1);
        end
        wait_out(6000);
        rnd_ready = 1'b0;
        wait_out(100);
        tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (stab_err - s0 !== 0) begin fails++; $display("FAIL rnd_stable got=%0d unstable_cycles exp=0", stab_err - s0); end
    endtask

    task automatic test_len_err;
        int e0;
        for (int c = 0; c < 2; c++) begin
            rnd_ready = 1'b0;
            clear_q();
            e0 = err_cnt;
            for (int i = 0; i < 48; i++) sym_dat[i] = $urandom;
            model_symbol(1'b0);
            if (c == 0) drive_symbol(1'b0, 29, 1'b0, 1'b0);
            else        drive_symbol(1'b0, -1, 1'b1, 1'b0);
            wait_out(500);
            tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL len%0d_err_pulses got=%0d exp=1", c, err_cnt - e0); end
            tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL len%0d_count got=%0d exp=%0d", c, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL len%0d_beat%0d got=%h exp=%h", c, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit acc;
        int n;
        rnd_ready = 1'b0;
        clear_q();
        for (int i = 0; i < 48; i++) sym_dat[i] = $urandom;
        for (int i = 0; i < 48; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = sym_dat[i];
            s_tuser  = (i == 0);
            s_tlast  = (i == 47);
            n = 0;
            do begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                n++;
            end while (!acc && n < 200);
            if (got_q.size() >= 40) break;
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid got=%b exp=0", m_tvalid); end
        tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL midrst_tdata got=%h exp=0", m_tdata); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL midrst_tlast got=%b exp=0", m_tlast); end
        tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL midrst_tready got=%b exp=0", s_tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        k_model = 0;
        for (int i = 0; i < 48; i++) sym_dat[i] = $urandom;
        model_symbol(1'b0);
        drive_symbol(1'b0, -1, 1'b0, 1'b0);
        wait_out(500);
        tests++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL midrst_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 8) begin
            tests++; if (got_q[7] !== 33'h7FFF) begin fails++; $display("FAIL midrst_sc7 got=%h exp=%h", got_q[7], 33'h7FFF); end
        end
    endtask

    task automatic test_pol_off;
        int in_cnt;
        int out_cnt;
        int cyc_n;
        int sc;
        int e2;
        logic [23:0] expv;
        in_cnt = 0; out_cnt = 0; cyc_n = 0; e2 = 0;
        s2_tvalid = 1'b1;
        s2_tdata  = 24'($urandom);
        s2_tlast  = 1'b0;
        s2_tuser  = 1'b1;
        while (out_cnt < 130 * 64 && cyc_n < 130 * 64 + 2000) begin
            @(negedge clk);
            if (err2) e2++;
            if (m2_tvalid && m2_tready) begin
                sc = out_cnt % 64;
                if (sc == 7 || sc == 21 || sc == 43 || sc == 57) begin
                    expv = (sc == 21) ? 24'h000801 : 24'h0007FF;
                    tests++;
                    if (m2_tdata !== expv) begin
                        fails++; $display("FAIL poloff_pilot sym=%0d sc=%0d got=%h exp=%h", out_cnt / 64, sc, m2_tdata, expv);
                    end
                end
                tests++;
                if (m2_tlast !== (sc == 63)) begin
                    fails++; $display("FAIL poloff_tlast beat=%0d got=%b exp=%b", out_cnt, m2_tlast, (sc == 63));
                end
                out_cnt++;
            end
            if (s2_tvalid && s2_tready) in_cnt++;
            @(posedge clk);
            #1;
            cyc_n++;
            s2_tdata = 24'($urandom);
            s2_tlast = (in_cnt % 48 == 47);
            s2_tuser = (in_cnt % 48 == 0) && ($urandom_range(0, 1) == 1);
        end
        s2_tvalid = 1'b0;
        tests++; if (out_cnt !== 130 * 64) begin fails++; $display("FAIL poloff_count got=%0d exp=%0d", out_cnt, 130 * 64); end
        tests++; if (e2 !== 0) begin fails++; $display("FAIL poloff_err_len got=%0d exp=0", e2); end
    endtask

    initial begin
        logic [6:0] st;
        rst       = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tlast   = 1'b0;
        s_tuser   = 1'b0;
        m_tready  = 1'b1;
        s2_tvalid = 1'b0;
        s2_tdata  = '0;
        s2_tlast  = 1'b0;
        s2_tuser  = 1'b0;
        m2_tready = 1'b1;
        // 802.11 polarity: x^7+x^4+1 from all ones, output s[6]^s[3] shifted in
        st = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            pol_tbl[i] = st[6] ^ st[3];
            st = {st[5:0], st[6] ^ st[3]};
        end
        test_reset();
        test_one_symbol();
        test_back_to_back();
        test_random_backpressure();
        test_len_err();
        test_reset_mid();
        test_pol_off();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pilot_insert_axis_param.md
Name: pilot_insert_axis_param

Overview:
Parametrised OFDM pilot/null inserter for the TX chain. It sits between the QAM mapper and the IFFT. Each OFDM symbol takes 48 data samples on an AXI-Stream input and emits 64 subcarriers in IFFT natural order: nulls at DC and the guard band, four pilots, and data on the rest. Compared with the previous generation it adds generic sample width and amplitude, in-block 127-length pilot polarity scrambling with frame restart, a length-error flag, and a registered-ready output stage that replaces the external FIFO.

Parameters:
DW, 16, width of each I/Q component; tdata is 2*DW.
PILOT_AMP, 2**(DW-1)-1, pilot magnitude; negative pilot is -PILOT_AMP in two's complement (0x8001 at DW=16).
POL_EN, 1, 1 = multiply pilots by 802.11 polarity sequence p_n; 0 = p_n always +1.
POL_SEED, 7'h7F, scrambler state loaded at frame start.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  input data valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  2*DW  {Q,I} data subcarrier
s_axis_tlast  in  1  last data sample of OFDM symbol
s_axis_tuser  in  1  first sample of frame (restart polarity)
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  2*DW  {Q,I} subcarrier
m_axis_tlast  out  1  subcarrier 63 of symbol
err_len  out  1  one-cycle pulse on tlast/count mismatch

Behaviour:
- Reset (rst = 1 at a clk edge) has the following effect:
  - m_axis_tvalid, m_axis_tlast, err_len and m_axis_tdata go to 0; s_axis_tready goes to 0.
  - sc_idx goes to 0; the polarity LFSR loads POL_SEED; the skid buffer is emptied.
  - Reset mid-symbol discards the partial symbol. No padding is emitted.
- Subcarrier class per sc_idx (0..63):
  - NULL: 0 and 27..37; value {0,0}.
  - PILOT: 7, 21, 43, 57.
  - DATA: all others, 48 in total.
- Pilot I value is base * p_n * PILOT_AMP, and pilot Q is 0.
  - base: +1 at sc 7, 43 and 57; -1 at sc 21.
  - p_n = +1 if the scrambler output bit is 0, -1 if it is 1.
- Polarity scrambler: x^7+x^4+1, one step per symbol; bit = s[6]^s[3], shifted in.
  - From seed 7'h7F the p sequence starts +1,+1,+1,+1,-1,-1,-1,+1.
  - It wraps naturally after 127 symbols.
- Symbol gating (IDLE state):
  - At sc_idx 0 the block emits nothing until s_axis_tvalid = 1. Input is peeked here, not consumed.
  - If s_axis_tuser = 1 at that point, the LFSR reloads POL_SEED before this symbol's pilots.
  - Otherwise the LFSR steps once at each symbol start, except the first symbol after reset.
- FSM states: IDLE, NULL, DATA, PILOT.
  - The state is derived from class(sc_idx); IDLE applies only at sc_idx 0 while waiting for input.
  - sc_idx advances on each write into the output stage and wraps 63 -> 0.
- Handshake:
  - s_axis_tready = stage_ready AND state == DATA.
  - NULL and PILOT entries are generated whenever stage_ready = 1, with no input dependence.
  - stage_ready is the skid-buffer ready, a registered signal with no combinational path from m_axis_tready.
- Latency: exactly 1 cycle from an input handshake (or generated entry) to m_axis_tvalid with an empty skid buffer.
  - Sustains 1 sample/clk with m_axis_tready held high.
- m_axis_tlast = 1 only on sc 63. Output tlast comes from the counter and never from s_axis_tlast.
- err_len pulses for one cycle on either mismatch below; there is no recovery action and counting stays authoritative:
  - s_axis_tlast = 1 on a data sample other than the 48th (sc 63);
  - s_axis_tlast = 0 on the 48th data sample.
- Backpressure while m_axis_tready = 0: output data, last and valid must hold stable (AXI rule).
- s_axis_tuser on a non-first sample is ignored.

Decomposition:
- Package pilot_insert_pkg holds:
  - enum sc_class_t {SC_NULL, SC_DATA, SC_PILOT};
  - function sc_class(idx);
  - function pilot_base_neg(idx);
  - localparams NFFT=64, N_DATA=48, POL_POLY taps.
- Sub-module axis_skid_buf #(W) is a 2-entry registered-ready output stage (tdata+tlast). It is reusable elsewhere in the TX chain.

Test Plan:
- One symbol, DW=16, data I=1..48, Q=0, tuser on the first sample, ready always high. Required output is 64 beats:
  - sc0 = 0; sc1..6 = 1..6; sc7 = 0x00007FFF; sc21 I = 0x8001;
  - sc27..37 = 0; sc43 and sc57 = 0x00007FFF;
  - tlast only on beat 63; no err_len.
- 8 back-to-back symbols, tuser on symbol 0. Pilot sign at sc7 must follow +,+,+,+,-,-,-,+. A second tuser at symbol 5 must restart at +.
- Random m_axis_tready (50%) plus random s_axis_tvalid gaps. The output must equal the ideal-ready reference, and tdata must be stable whenever valid && !ready.
- tlast on data sample 30: err_len pulses once and the output still emits 64 beats with tlast at 63. Missing tlast on sample 48: err_len pulses once.
- Assert rst at sc 40 of a symbol, then send a fresh symbol. Outputs must go to 0 the next cycle, and the new symbol must start at sc0 with polarity +1.
- POL_EN=0, DW=12: every pilot I = 0x7FF except sc21 = 0x801 across 130 symbols.
